// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID/EX hazard signals between pipeline and hazard controller
interface pipe_hazard_ctrl_if;
    logic        id_valid;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_call;
    logic        id_ret;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [3:0]  ex_reg_rd;
    logic        ex_branch_taken;
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_flush;
    logic        pc_hazard;
    logic [15:0] stall_cnt;

    // Pipeline side: presents ID/EX state, consumes stall/flush controls
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_call, id_ret,
        output ex_mem_read, ex_reg_write, ex_reg_rd, ex_branch_taken,
        input  pc_stall, ifid_stall, ifid_flush, idex_flush, pc_hazard, stall_cnt
    );

    // Hazard controller side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_call, id_ret,
        input  ex_mem_read, ex_reg_write, ex_reg_rd, ex_branch_taken,
        output pc_stall, ifid_stall, ifid_flush, idex_flush, pc_hazard, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, branch flush and call/ret drain control
module pipe_hazard_ctrl #(
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus
);
    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [15:0] r_stall_cnt;

    logic        w_luh;
    logic        w_drain_entry;
    logic        w_pc_stall;
    logic        w_ifid_stall;
    logic        w_ifid_flush;
    logic        w_idex_flush;
    logic        w_pc_hazard;

    // Load-use hazard: ID reads the register a load in EX is about to write (R0 exempt)
    always_comb begin
        w_luh = bus.id_valid & bus.ex_mem_read & bus.ex_reg_write & (bus.ex_reg_rd != 4'd0) &
                ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_reg_rd)) |
                 (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_reg_rd)));
        w_drain_entry = (r_state == ST_RUN) & bus.id_valid & (bus.id_call | bus.id_ret) &
                        ~w_luh & ~bus.ex_branch_taken;
    end

    // Control outputs by priority: branch flush > drain > load-use; pc_hazard tracks drain only
    always_comb begin
        w_pc_stall   = 1'b0;
        w_ifid_stall = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_pc_hazard  = 1'b0;
        if (rst_n) begin
            w_pc_hazard = (r_state == ST_DRAIN);
            if (bus.ex_branch_taken) begin
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
            end else if (r_state == ST_DRAIN) begin
                w_pc_stall   = 1'b1;
                w_ifid_flush = 1'b1;
            end else if (w_luh) begin
                w_pc_stall   = 1'b1;
                w_ifid_stall = 1'b1;
                w_idex_flush = 1'b1;
            end
        end
    end

    // RUN/DRAIN sequencing; the drain runs to completion even across a branch flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_drain_entry) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= 3'(DRAIN_CYC - 1);
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles the PC was held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (w_pc_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.pc_stall   = w_pc_stall;
    assign bus.ifid_stall = w_ifid_stall;
    assign bus.ifid_flush = w_ifid_flush;
    assign bus.idex_flush = w_idex_flush;
    assign bus.pc_hazard  = w_pc_hazard;
    assign bus.stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] exp_sc;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.DRAIN_CYC(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1;
        logic       u2;
        logic       call;
        logic       ret;
        logic       mr;
        logic       rw;
        logic [3:0] rd;
        logic       br;
    } in_t;

    // expected output order: {pc_stall, ifid_stall, ifid_flush, idex_flush, pc_hazard}
    typedef struct {
        in_t        in;
        logic [4:0] exp;
        string      name;
    } vec_t;

    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_LUH   = 5'b11010;
    localparam logic [4:0] O_BR    = 5'b00110;
    localparam logic [4:0] O_DRAIN = 5'b10101;
    localparam logic [4:0] O_BRDR  = 5'b00111;

    localparam in_t I_IDLE = '0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input logic rstn, input in_t in, input logic [4:0] exp, input string name);
        @(negedge clk);
        rst_n                = rstn;
        bus.id_valid         = in.v;
        bus.id_rs1           = in.rs1;
        bus.id_rs2           = in.rs2;
        bus.id_use_rs1       = in.u1;
        bus.id_use_rs2       = in.u2;
        bus.id_call          = in.call;
        bus.id_ret           = in.ret;
        bus.ex_mem_read      = in.mr;
        bus.ex_reg_write     = in.rw;
        bus.ex_reg_rd        = in.rd;
        bus.ex_branch_taken  = in.br;
        #1;
        check({name, ".out"}, {11'd0, bus.pc_stall, bus.ifid_stall, bus.ifid_flush,
                               bus.idex_flush, bus.pc_hazard}, {11'd0, exp});
        check({name, ".cnt"}, bus.stall_cnt, exp_sc);
        if (!rstn) exp_sc = 16'd0;
        else if (exp[4] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    endtask

    function automatic in_t mk(logic v, logic [3:0] rs1, logic [3:0] rs2, logic u1, logic u2,
                               logic call, logic ret, logic mr, logic rw, logic [3:0] rd, logic br);
        in_t r;
        r = '{v, rs1, rs2, u1, u2, call, ret, mr, rw, rd, br};
        return r;
    endfunction

    vec_t vecs[$];
    in_t  luh5;
    in_t  call_i;

    initial begin
        checks = 0;
        errors = 0;
        exp_sc = 16'd0;
        luh5   = mk(1, 4'd0, 4'd5, 0, 1, 0, 0, 1, 1, 4'd5, 0);
        call_i = mk(1, 4'd0, 4'd0, 0, 0, 1, 0, 0, 0, 4'd0, 0);

        vecs.push_back('{I_IDLE, O_NONE, "idle"});
        vecs.push_back('{luh5, O_LUH, "luh_rs2"});
        vecs.push_back('{mk(1, 0, 5, 0, 1, 0, 0, 1, 1, 0, 0), O_NONE, "rd0_no_luh"});
        vecs.push_back('{mk(1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0), O_NONE, "r0_match"});
        vecs.push_back('{mk(1, 7, 2, 1, 0, 0, 0, 1, 1, 7, 0), O_LUH, "luh_rs1"});
        vecs.push_back('{mk(1, 7, 2, 0, 0, 0, 0, 1, 1, 7, 0), O_NONE, "no_use_rs1"});
        vecs.push_back('{mk(1, 0, 5, 0, 1, 0, 0, 0, 1, 5, 0), O_NONE, "no_memread"});
        vecs.push_back('{mk(1, 0, 5, 0, 1, 0, 0, 1, 0, 5, 0), O_NONE, "no_regwrite"});
        vecs.push_back('{mk(0, 0, 5, 0, 1, 0, 0, 1, 1, 5, 0), O_NONE, "id_invalid"});
        vecs.push_back('{mk(1, 0, 5, 0, 1, 0, 0, 1, 1, 5, 1), O_BR, "br_over_luh"});
        vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_BR, "br_only"});
        vecs.push_back('{mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), O_NONE, "call_invalid"});
        vecs.push_back('{mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), O_BR, "ret_with_br"});
        vecs.push_back('{mk(1, 0, 5, 0, 1, 1, 0, 1, 1, 5, 0), O_LUH, "call_with_luh"});
        vecs.push_back('{I_IDLE, O_NONE, "idle_no_drain"});

        rst_n = 1'b0;
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0;
        bus.id_use_rs2 = 0; bus.id_call = 0; bus.id_ret = 0; bus.ex_mem_read = 0;
        bus.ex_reg_write = 0; bus.ex_reg_rd = 0; bus.ex_branch_taken = 0;
        repeat (2) @(posedge clk);
        step(0, luh5, O_NONE, "reset_force");
        step(0, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1), O_NONE, "reset_force_br");

        foreach (vecs[i]) step(1, vecs[i].in, vecs[i].exp, vecs[i].name);

        // call drain: 3 drain cycles, call and luh ignored inside the drain
        step(1, call_i, O_NONE, "call_enter");
        step(1, I_IDLE, O_DRAIN, "drain1");
        step(1, mk(1, 0, 5, 0, 1, 1, 0, 1, 1, 5, 0), O_DRAIN, "drain2_ign");
        step(1, I_IDLE, O_DRAIN, "drain3");
        step(1, I_IDLE, O_NONE, "drain_done");
        step(1, I_IDLE, O_NONE, "run_after");

        // call blocked by load-use, then enters drain next cycle
        step(1, mk(1, 0, 5, 0, 1, 1, 0, 1, 1, 5, 0), O_LUH, "call_luh_stall");
        step(1, call_i, O_NONE, "call_luh_enter");
        for (int k = 0; k < 3; k++) step(1, I_IDLE, O_DRAIN, "call_luh_drain");
        step(1, I_IDLE, O_NONE, "call_luh_done");

        // branch inside drain: flush wins, drain length unchanged
        step(1, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), O_NONE, "ret_enter");
        step(1, I_IDLE, O_DRAIN, "ret_drain1");
        step(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_BRDR, "ret_drain_br");
        step(1, I_IDLE, O_DRAIN, "ret_drain3");
        step(1, I_IDLE, O_NONE, "ret_done");

        // reset on the second drain cycle aborts the drain
        step(1, call_i, O_NONE, "rst_call_enter");
        step(1, I_IDLE, O_DRAIN, "rst_drain1");
        step(0, I_IDLE, O_NONE, "rst_mid_drain");
        step(0, I_IDLE, O_NONE, "rst_hold");
        step(1, I_IDLE, O_NONE, "rst_release_run");
        step(1, I_IDLE, O_NONE, "rst_release_run2");

        // saturation: hold a load-use hazard for many cycles
        @(negedge clk);
        bus.id_valid = 1; bus.id_rs2 = 5; bus.id_use_rs2 = 1;
        bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_reg_rd = 5;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", bus.stall_cnt, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        check("sat_ffff", bus.stall_cnt, 16'hFFFF);
        check("sat_still_stall", {15'd0, bus.pc_stall}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
